// File: rtl/core_bus_arbiter.sv
// Shares one memory port between an instruction-fetch and a load/store requester.
// Load/store wins ties until a waiting fetch has lost STARVE_LIMIT grants in a row.
module core_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_ack_out,
    output logic [31:0] if_rdata_out,
    input  logic        ls_req_in,
    input  logic        ls_we_in,
    input  logic [31:0] ls_addr_in,
    input  logic [31:0] ls_wdata_in,
    input  logic [3:0]  ls_be_in,
    output logic        ls_ack_out,
    output logic [31:0] ls_rdata_out,
    output logic        err_out,
    output logic        if_stall_out,
    output logic        ls_stall_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_be_out,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ack_in
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned CntW    = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyLs
    } state_e;

    state_e             state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               if_ack_q, if_ack_d;
    logic               ls_ack_q, ls_ack_d;
    logic               err_q, err_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        ls_rdata_q, ls_rdata_d;

    logic starved;
    logic timed_out;

    assign starved   = (starve_q == StarveW'(STARVE_LIMIT));
    assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = '0;
        ls_rdata_d  = '0;

        case (state_q)
            StIdle: begin
                // The requester still holds its request during its ack cycle, so no grant then.
                if (!if_ack_q && !ls_ack_q) begin
                    if (ls_req_in && !(if_req_in && starved)) begin
                        state_d     = StBusyLs;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we_in;
                        mem_addr_d  = ls_addr_in;
                        mem_wdata_d = ls_wdata_in;
                        mem_be_d    = ls_be_in;
                        if (if_req_in && !starved) begin
                            starve_d = starve_q + StarveW'(1);
                        end
                    end else if (if_req_in) begin
                        state_d     = StBusyIf;
                        cnt_d       = '0;
                        starve_d    = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_in;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                    end
                end
            end
            StBusyIf, StBusyLs: begin
                if (mem_ack_in || timed_out) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack_in;
                    if (state_q == StBusyIf) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_ack_in ? mem_rdata_in : '0;
                    end else begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = mem_ack_in ? mem_rdata_in : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_be_out    = mem_be_q;
    assign if_ack_out    = if_ack_q;
    assign ls_ack_out    = ls_ack_q;
    assign err_out       = err_q;
    assign if_rdata_out  = if_rdata_q;
    assign ls_rdata_out  = ls_rdata_q;
    assign if_stall_out  = if_req_in & ~if_ack_q;
    assign ls_stall_out  = ls_req_in & ~ls_ack_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: requester tasks push expected responses, a negedge monitor
// plays the memory, judges each grant and pops/compares every ack.
module tb_core_bus_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned TIMEOUT      = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_in, if_ack_out, ls_req_in, ls_we_in, ls_ack_out, err_out;
    logic [31:0] if_addr_in, if_rdata_out, ls_addr_in, ls_wdata_in, ls_rdata_out;
    logic [3:0]  ls_be_in, mem_be_out;
    logic        if_stall_out, ls_stall_out, mem_req_out, mem_we_out, mem_ack_in;
    logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;

    core_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_ack_out(if_ack_out), .if_rdata_out(if_rdata_out),
        .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_addr_in(ls_addr_in),
        .ls_wdata_in(ls_wdata_in), .ls_be_in(ls_be_in),
        .ls_ack_out(ls_ack_out), .ls_rdata_out(ls_rdata_out), .err_out(err_out),
        .if_stall_out(if_stall_out), .ls_stall_out(ls_stall_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_be_out(mem_be_out),
        .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        if_exp_q[$];
    exp_t        ls_exp_q[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_grant_cyc = 0;
    int          ls_ack_cyc = 0;
    int          starve_m = 0;
    int          xcnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] xaddr = '0;
    logic [31:0] if_cur_addr = '0, ls_cur_addr = '0, ls_cur_wdata = '0;
    logic        ls_cur_we = 1'b0;
    logic [3:0]  ls_cur_be = '0;
    logic        mreq_p = 1'b0, ack_p = 1'b0, ifreq_p = 1'b0, lsreq_p = 1'b0, rst_p = 1'b0;
    logic [31:0] snap_addr = '0, snap_wdata = '0;
    logic [4:0]  snap_webe = '0;

    // Memory model: ack latency and contents are pure functions of the address.
    function automatic int mem_delay(input logic [31:0] a);
        if (a[31:28] == 4'hF) return 1000;
        return int'({a[6], a[9:7]});
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic exp_t predict(input logic [31:0] a);
        exp_t e;
        e.err   = (mem_delay(a) >= int'(TIMEOUT));
        e.rdata = e.err ? 32'h0 : mem_word(a);
        return e;
    endfunction

    function automatic logic [31:0] rand_addr(input logic [3:0] tag);
        logic [31:0] a;
        a        = $urandom;
        a[27:24] = tag;
        a[31:28] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'h0;
        a[1:0]   = 2'b00;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic if_xfer(input logic [31:0] a);
        bit got = 0;
        if_req_in   = 1'b1;
        if_addr_in  = a;
        if_cur_addr = a;
        if_exp_q.push_back(predict(a));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if_ack_out) begin got = 1; break; end
        end
        chk("if_ack_arrived", 32'(got), 32'd1);
        step(1);
        if_req_in = 1'b0;
    endtask

    task automatic ls_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        bit got = 0;
        ls_req_in    = 1'b1;
        ls_we_in     = we;
        ls_addr_in   = a;
        ls_wdata_in  = wd;
        ls_be_in     = be;
        ls_cur_we    = we;
        ls_cur_addr  = a;
        ls_cur_wdata = wd;
        ls_cur_be    = be;
        ls_exp_q.push_back(predict(a));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ls_ack_out) begin got = 1; ls_ack_cyc = cyc; break; end
        end
        chk("ls_ack_arrived", 32'(got), 32'd1);
        step(1);
        ls_req_in = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        int   winner;
        logic exp_ls, act_ls, act_if;
        mem_ack_in   = 1'b0;
        mem_rdata_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) starve_m = 0;
            if (if_ack_out && ls_ack_out) chk("both_acks", 32'd1, 32'd0);
            if (if_ack_out) begin
                if (if_exp_q.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = if_exp_q.pop_front();
                    chk("if_rdata", if_rdata_out, e.rdata);
                    chk("if_err", 32'(err_out), 32'(e.err));
                end
            end else chk("if_rdata_quiet", if_rdata_out, 32'h0);
            if (ls_ack_out) begin
                if (ls_exp_q.size() == 0) chk("ls_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = ls_exp_q.pop_front();
                    chk("ls_rdata", ls_rdata_out, e.rdata);
                    chk("ls_err", 32'(err_out), 32'(e.err));
                end
            end else chk("ls_rdata_quiet", ls_rdata_out, 32'h0);
            if (!if_ack_out && !ls_ack_out) chk("err_quiet", 32'(err_out), 32'd0);
            chk("if_stall", 32'(if_stall_out), 32'(if_req_in & ~if_ack_out));
            chk("ls_stall", 32'(ls_stall_out), 32'(ls_req_in & ~ls_ack_out));
            // A free arbiter must grant a pending request on the very next cycle.
            if (rst_n && rst_p && !mreq_p)
                chk("grant_latency", 32'(mem_req_out), 32'(!ack_p && (ifreq_p || lsreq_p)));
            if (rst_n && mem_req_out && !mreq_p) begin
                exp_ls = lsreq_p && !(ifreq_p && starve_m == int'(STARVE_LIMIT));
                act_ls = lsreq_p && mem_we_out == ls_cur_we && mem_addr_out == ls_cur_addr &&
                         mem_wdata_out == ls_cur_wdata && mem_be_out == ls_cur_be;
                act_if = ifreq_p && !mem_we_out && mem_addr_out == if_cur_addr &&
                         mem_wdata_out == 32'h0 && mem_be_out == 4'hF;
                winner = act_ls ? 1 : (act_if ? 0 : 2);
                grant_log.push_back(winner);
                chk("grant_winner", 32'(winner), exp_ls ? 32'd1 : 32'd0);
                if (!exp_ls) starve_m = 0;
                else if (ifreq_p && starve_m < int'(STARVE_LIMIT)) starve_m++;
                snap_addr      = mem_addr_out;
                snap_wdata     = mem_wdata_out;
                snap_webe      = {mem_we_out, mem_be_out};
                xaddr          = mem_addr_out;
                xcnt           = 0;
                last_grant_cyc = cyc;
            end else if (rst_n && mem_req_out) begin
                xcnt++;
                chk("hold_addr", mem_addr_out, snap_addr);
                chk("hold_wdata", mem_wdata_out, snap_wdata);
                chk("hold_we_be", 32'({mem_we_out, mem_be_out}), 32'(snap_webe));
            end
            mem_ack_in   = force_ack;
            mem_rdata_in = '0;
            if (rst_n && mem_req_out && xcnt == mem_delay(xaddr)) begin
                mem_ack_in   = 1'b1;
                mem_rdata_in = mem_word(xaddr);
            end
            mreq_p  = mem_req_out;
            ack_p   = if_ack_out | ls_ack_out;
            ifreq_p = if_req_in;
            lsreq_p = ls_req_in;
            rst_p   = rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        if_req_in = 0; if_addr_in = '0; ls_req_in = 0; ls_we_in = 0;
        ls_addr_in = '0; ls_wdata_in = '0; ls_be_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req_out), 32'd0);
        chk("rst_mem_addr", mem_addr_out, 32'h0);
        chk("rst_mem_wdata", mem_wdata_out, 32'h0);
        chk("rst_mem_we_be", 32'({mem_we_out, mem_be_out}), 32'd0);
        chk("rst_acks_err", 32'({if_ack_out, ls_ack_out, err_out}), 32'd0);
        chk("rst_rdata", if_rdata_out | ls_rdata_out, 32'h0);
        step(3);
        rst_n = 1'b1;
        step(1);

        // Fetch only, memory acks two cycles after the request rises.
        fork
            if_xfer(32'h100);
            begin
                @(negedge clk);
                chk("if_req_not_yet", 32'(mem_req_out), 32'd0);
                @(negedge clk);
                chk("if_req_next", 32'(mem_req_out), 32'd1);
                chk("if_mem_addr", mem_addr_out, 32'h100);
                chk("if_mem_we", 32'(mem_we_out), 32'd0);
            end
        join
        @(negedge clk);
        chk("if_ack_one_cycle", 32'(if_ack_out), 32'd0);
        step(1);

        // Continuous contention: four stores win, the fifth grant goes to the fetch.
        grant_log.delete();
        fork
            if_xfer(32'h300);
            for (int k = 0; k < 5; k++) ls_xfer(1'b1, 32'h2000, 32'hCAFE_0000 + k, 4'h3);
        join
        chk("starve_grants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("starve_order", 32'((k < grant_log.size()) ? grant_log[k] : 9),
                (k == 4) ? 32'd0 : 32'd1);
        grant_log.delete();
        fork
            if_xfer(32'h304);
            ls_xfer(1'b0, 32'h2040, 32'h0, 4'hF);
        join
        chk("starve_cleared_ls", 32'((grant_log.size() > 0) ? grant_log[0] : 9), 32'd1);
        chk("starve_cleared_if", 32'((grant_log.size() > 1) ? grant_log[1] : 9), 32'd0);

        // Load with no memory ack times out.
        ls_xfer(1'b0, 32'hF000_0040, 32'h0, 4'hF);
        chk("timeout_latency", 32'(ls_ack_cyc - last_grant_cyc), 32'(TIMEOUT));
        ls_xfer(1'b0, 32'h0000_0180, 32'h0, 4'hF);

        // Requester address changes right after the grant.
        ls_req_in = 1'b1; ls_we_in = 1'b0; ls_addr_in = 32'h40; ls_wdata_in = '0;
        ls_be_in = 4'hF;
        ls_cur_we = 1'b0; ls_cur_addr = 32'h40; ls_cur_wdata = '0; ls_cur_be = 4'hF;
        ls_exp_q.push_back(predict(32'h40));
        step(1);
        ls_addr_in = 32'h80;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ls_ack_out) begin seen = 1; break; end
            if (mem_req_out) chk("addr_hold_after_change", mem_addr_out, 32'h40);
        end
        chk("addr_change_ack", 32'(seen), 32'd1);
        step(1);
        ls_req_in = 1'b0;
        step(1);

        // Stray memory ack while idle.
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_no_ack", 32'({if_ack_out, ls_ack_out, mem_req_out}), 32'd0);
        end
        step(1);
        if_xfer(32'h108);

        // Reset in the middle of a fetch, then a late ack.
        if_req_in = 1'b1; if_addr_in = 32'hF000_0200; if_cur_addr = 32'hF000_0200;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req_out) begin seen = 1; break; end
        end
        chk("rst_mid_granted", 32'(seen), 32'd1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(mem_req_out), 32'd0);
        chk("rst_mid_addr", mem_addr_out, 32'h0);
        chk("rst_mid_no_ack", 32'({if_ack_out, err_out}), 32'd0);
        if_req_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("late_ack_ignored", 32'({if_ack_out, ls_ack_out, mem_req_out}), 32'd0);
        end
        step(1);

        // Randomised traffic from both requesters.
        fork
            for (int k = 0; k < 30; k++) begin
                step($urandom_range(0, 3));
                if_xfer(rand_addr(4'h1));
            end
            for (int k = 0; k < 30; k++) begin
                step($urandom_range(0, 3));
                ls_xfer(1'($urandom_range(0, 1)), rand_addr(4'h2), $urandom,
                        4'($urandom_range(0, 15)));
            end
        join
        step(3);
        chk("if_exp_drained", 32'(if_exp_q.size()), 32'd0);
        chk("ls_exp_drained", 32'(ls_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 The parameter STARVE_LIMIT SHALL default to 4 and set the maximum number of consecutive load/store wins over a pending fetch.
REQ-002 The parameter TIMEOUT SHALL default to 15 and set the maximum number of cycles a granted transfer may wait for mem_ack_in.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 Port if_req_in SHALL be an input, 1 bit wide: fetch request, held high until if_ack_out.
REQ-006 Port if_addr_in SHALL be an input, 32 bits wide: fetch address.
REQ-007 Port if_ack_out SHALL be an output, 1 bit wide: one-cycle fetch-completion pulse.
REQ-008 Port if_rdata_out SHALL be an output, 32 bits wide: fetched instruction, valid while if_ack_out is high.
REQ-009 Port ls_req_in SHALL be an input, 1 bit wide: load/store request, held high until ls_ack_out.
REQ-010 Port ls_we_in SHALL be an input, 1 bit wide: 1 = store, 0 = load.
REQ-011 Port ls_addr_in SHALL be an input, 32 bits wide: data address.
REQ-012 Port ls_wdata_in SHALL be an input, 32 bits wide: store data.
REQ-013 Port ls_be_in SHALL be an input, 4 bits wide: byte enables.
REQ-014 Port ls_ack_out SHALL be an output, 1 bit wide: one-cycle load/store-completion pulse.
REQ-015 Port ls_rdata_out SHALL be an output, 32 bits wide: load data, valid while ls_ack_out is high.
REQ-016 Port err_out SHALL be an output, 1 bit wide: high with an ack pulse when that transfer timed out.
REQ-017 Port if_stall_out SHALL be an output, 1 bit wide: equal to if_req_in & ~if_ack_out.
REQ-018 Port ls_stall_out SHALL be an output, 1 bit wide: equal to ls_req_in & ~ls_ack_out.
REQ-019 Port mem_req_out SHALL be an output, 1 bit wide: request to the shared memory.
REQ-020 Port mem_we_out SHALL be an output, 1 bit wide: memory write enable.
REQ-021 Port mem_addr_out SHALL be an output, 32 bits wide: memory address.
REQ-022 Port mem_wdata_out SHALL be an output, 32 bits wide: memory write data.
REQ-023 Port mem_be_out SHALL be an output, 4 bits wide: memory byte enables.
REQ-024 Port mem_rdata_in SHALL be an input, 32 bits wide: memory read data, valid with mem_ack_in.
REQ-025 Port mem_ack_in SHALL be an input, 1 bit wide: memory completion strobe.

Function
REQ-026 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_LS.
REQ-027 In IDLE with only ls_req_in high, the next state SHALL be BUSY_LS.
REQ-028 In IDLE with only if_req_in high, the next state SHALL be BUSY_IF.
REQ-029 In IDLE with both requests high, BUSY_LS SHALL win unless starve_cnt == STARVE_LIMIT, in which case BUSY_IF SHALL win.
REQ-030 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on every grant to LS while if_req_in is high.
REQ-031 starve_cnt SHALL clear on every grant to IF.
REQ-032 On grant, the winner's address, write enable, write data and byte enables SHALL be registered onto the mem_* outputs (IF grant: we=0, be=4'hF, wdata=0), and mem_req_out SHALL be 1 in the next cycle.
REQ-033 A request sampled in IDLE in cycle N SHALL produce mem_req_out=1 in cycle N+1; mem_* outputs SHALL stay constant while in BUSY_*.
REQ-034 In BUSY_x, in the cycle mem_ack_in=1: mem_rdata_in SHALL be registered to x_rdata_out, x_ack_out SHALL pulse high for exactly the following cycle, mem_req_out SHALL drop, and the state SHALL return to IDLE.
REQ-035 Minimum transfer turnaround SHALL be 3 cycles (grant, ack, idle); no back-to-back grant within the ack cycle.
REQ-036 A cycle counter SHALL clear on entry to BUSY_*.
REQ-037 If the counter reaches TIMEOUT with no mem_ack_in, the arbiter SHALL drop mem_req_out, pulse x_ack_out with err_out=1 and x_rdata_out=0, and return to IDLE.
REQ-038 mem_ack_in arriving in IDLE SHALL be ignored.
REQ-039 Requester attributes changing after grant SHALL NOT affect the transfer in progress.
REQ-040 ack and rdata outputs of the non-granted requester SHALL remain 0.

Reset
REQ-041 While rst_n=0, the state SHALL be IDLE.
REQ-042 While rst_n=0, starve_cnt, the timeout counter, all mem_* outputs, both ack outputs, both rdata outputs and err_out SHALL be 0, taking effect immediately without a clock edge.
REQ-043 Reset asserted mid-transfer SHALL abandon the transfer without an ack pulse.
REQ-044 A mem_ack_in arriving after reset is released SHALL be ignored per REQ-038.

Verification
REQ-045 The bench SHALL cover: IF only, addr 0x100, memory acks 2 cycles after mem_req_out, rdata 0x00000013 -> mem_addr_out=0x100, we=0, if_ack_out one cycle with if_rdata_out=0x00000013.
REQ-046 The bench SHALL cover: both requesting continuously, LS store to 0x2000 with be=4'h3, memory acks immediately -> grants LS, LS, LS, LS, then IF on the 5th grant, starve_cnt back to 0.
REQ-047 The bench SHALL cover: LS load, memory never acks -> ls_ack_out with err_out=1 and ls_rdata_out=0 exactly TIMEOUT cycles after grant, then IDLE.
REQ-048 The bench SHALL cover: rst_n pulled low while in BUSY_IF with no ack pending -> mem_req_out=0 immediately, no if_ack_out, and a late mem_ack_in after release is ignored.
REQ-049 The bench SHALL cover: ls_addr_in changed from 0x40 to 0x80 one cycle after grant -> mem_addr_out stays 0x40 until ack.
REQ-050 The bench SHALL cover: mem_ack_in pulsed while IDLE -> no ack output and no state change.
